// File: rtl/rs232_register_bridge.sv
// Byte-stream to register-bus bridge: decodes 'W'/'R' packets from a receive FIFO,
// drives single-cycle bus strobes and queues ACK/NAK or read data into a transmit FIFO.
module rs232_register_bridge #(
   parameter int unsigned            TimeoutBits = 20,
   parameter logic [TimeoutBits-1:0] Timeout     = TimeoutBits'(500000)
) (
   input  logic        FIFO_Clk,
   input  logic        nReset,
   input  logic [9:0]  RxCount,
   input  logic [7:0]  RxData,
   output logic        Ack,
   input  logic        AckBusy,
   input  logic [9:0]  TxCount,
   output logic [7:0]  TxData,
   output logic        Send,
   input  logic        Busy,
   output logic [7:0]  Address,
   output logic [31:0] WrData,
   output logic        Write,
   output logic        Read,
   input  logic [31:0] RdData,
   output logic [7:0]  ErrorCount
);

   localparam logic [7:0] CmdWrite = 8'h57;
   localparam logic [7:0] CmdRead  = 8'h52;
   localparam logic [7:0] RespAck  = 8'h06;
   localparam logic [7:0] RespNak  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_EXEC_W, ST_EXEC_R, ST_CAPTURE, ST_RESP
   } state_t;

   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic                   send_q, send_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic [7:0]             address_q, address_d;
   logic [31:0]            wr_data_q, wr_data_d;
   logic                   write_q, write_d;
   logic                   read_q, read_d;
   logic [7:0]             error_count_q, error_count_d;
   logic [7:0]             rx_byte_q, rx_byte_d;
   logic                   is_write_q, is_write_d;
   logic [1:0]             idx_q, idx_d;
   logic [TimeoutBits-1:0] tmr_q, tmr_d;
   logic [31:0]            tx_buf_q, tx_buf_d;
   logic [2:0]             tx_left_q, tx_left_d;

   logic rx_ok_c, tx_ok_c, pop_c, err_inc_c;

   assign Ack        = ack_q;
   assign Send       = send_q;
   assign TxData     = tx_data_q;
   assign Address    = address_q;
   assign WrData     = wr_data_q;
   assign Write      = write_q;
   assign Read       = read_q;
   assign ErrorCount = error_count_q;

   // A new pop/push may start only once the previous handshake has fully retired.
   assign rx_ok_c = (RxCount != 10'd0) && !AckBusy && !ack_q;
   assign tx_ok_c = (TxCount != 10'd1023) && !Busy && !send_q;

   always_comb begin
      state_d       = state_q;
      ack_d         = ack_q;
      send_d        = send_q;
      tx_data_d     = tx_data_q;
      address_d     = address_q;
      wr_data_d     = wr_data_q;
      write_d       = 1'b0;
      read_d        = 1'b0;
      error_count_d = error_count_q;
      rx_byte_d     = rx_byte_q;
      is_write_d    = is_write_q;
      idx_d         = idx_q;
      tmr_d         = tmr_q;
      tx_buf_d      = tx_buf_q;
      tx_left_d     = tx_left_q;
      pop_c         = 1'b0;
      err_inc_c     = 1'b0;

      if (ack_q && AckBusy) ack_d = 1'b0;
      if (send_q && Busy) send_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_ok_c) begin
               pop_c     = 1'b1;
               rx_byte_d = RxData;
               state_d   = ST_CMD;
            end
         end
         ST_CMD: begin
            if (rx_byte_q == CmdWrite || rx_byte_q == CmdRead) begin
               is_write_d = (rx_byte_q == CmdWrite);
               state_d    = ST_ADDR;
            end else begin
               tx_buf_d  = {24'h0, RespNak};
               tx_left_d = 3'd1;
               err_inc_c = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_ADDR, ST_DATA: begin
            if (rx_ok_c) begin
               pop_c = 1'b1;
               if (state_q == ST_ADDR) begin
                  address_d = RxData;
                  idx_d     = 2'd0;
                  state_d   = is_write_q ? ST_DATA : ST_EXEC_R;
               end else begin
                  wr_data_d[{idx_q, 3'b000} +: 8] = RxData;
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = ST_EXEC_W;
               end
            end else if (RxCount == 10'd0) begin
               // Inter-byte silence: abort the partial packet once the budget is spent.
               if (tmr_q == '0) begin
                  idx_d     = 2'd0;
                  err_inc_c = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  tmr_d = tmr_q - TimeoutBits'(1);
               end
            end
         end
         ST_EXEC_W: begin
            write_d   = 1'b1;
            tx_buf_d  = {24'h0, RespAck};
            tx_left_d = 3'd1;
            state_d   = ST_RESP;
         end
         ST_EXEC_R: begin
            read_d  = 1'b1;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // Read is high for the first CAPTURE cycle; RdData is valid the cycle after.
            if (!read_q) begin
               tx_buf_d  = RdData;
               tx_left_d = 3'd4;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            if (tx_left_q != 3'd0) begin
               if (tx_ok_c) begin
                  send_d    = 1'b1;
                  tx_data_d = tx_buf_q[7:0];
                  tx_buf_d  = {8'h00, tx_buf_q[31:8]};
                  tx_left_d = tx_left_q - 3'd1;
               end
            end else if (!send_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop_c) ack_d = 1'b1;
      if (pop_c || (ack_q && AckBusy)) tmr_d = Timeout;
      if (err_inc_c && error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
   end

   always_ff @(posedge FIFO_Clk or negedge nReset) begin
      if (!nReset) begin
         state_q       <= ST_IDLE;
         ack_q         <= 1'b0;
         send_q        <= 1'b0;
         tx_data_q     <= 8'h00;
         address_q     <= 8'h00;
         wr_data_q     <= 32'h0;
         write_q       <= 1'b0;
         read_q        <= 1'b0;
         error_count_q <= 8'h00;
         rx_byte_q     <= 8'h00;
         is_write_q    <= 1'b0;
         idx_q         <= 2'd0;
         tmr_q         <= '0;
         tx_buf_q      <= 32'h0;
         tx_left_q     <= 3'd0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         send_q        <= send_d;
         tx_data_q     <= tx_data_d;
         address_q     <= address_d;
         wr_data_q     <= wr_data_d;
         write_q       <= write_d;
         read_q        <= read_d;
         error_count_q <= error_count_d;
         rx_byte_q     <= rx_byte_d;
         is_write_q    <= is_write_d;
         idx_q         <= idx_d;
         tmr_q         <= tmr_d;
         tx_buf_q      <= tx_buf_d;
         tx_left_q     <= tx_left_d;
      end
   end

endmodule

// File: tb/tb_rs232_register_bridge.sv
// Directed bench for rs232_register_bridge with behavioural RX/TX FIFO and bus-slave models.
module tb_rs232_register_bridge;

   localparam logic [19:0] TO = 20'd40;

   logic        FIFO_Clk = 1'b0;
   logic        nReset;
   logic [9:0]  RxCount;
   logic [7:0]  RxData;
   logic        Ack;
   logic        AckBusy;
   logic [9:0]  TxCount;
   logic [7:0]  TxData;
   logic        Send;
   logic        Busy;
   logic [7:0]  Address;
   logic [31:0] WrData;
   logic        Write;
   logic        Read;
   logic [31:0] RdData = 32'h0;
   logic [7:0]  ErrorCount;

   always #5 FIFO_Clk = ~FIFO_Clk;

   rs232_register_bridge #(.TimeoutBits(20), .Timeout(TO)) dut (
      .FIFO_Clk(FIFO_Clk), .nReset(nReset), .RxCount(RxCount), .RxData(RxData),
      .Ack(Ack), .AckBusy(AckBusy), .TxCount(TxCount), .TxData(TxData), .Send(Send),
      .Busy(Busy), .Address(Address), .WrData(WrData), .Write(Write), .Read(Read),
      .RdData(RdData), .ErrorCount(ErrorCount)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Receive FIFO model: pop takes two busy cycles, head advances at the end.
   logic [7:0] rx_mem [0:63];
   int rx_wr = 0;
   int rx_rd = 0;
   int rx_busy = 0;
   assign RxCount = 10'(rx_wr - rx_rd);
   assign RxData  = rx_mem[rx_rd[5:0]];
   assign AckBusy = (rx_busy != 0);
   always @(posedge FIFO_Clk) begin
      if (rx_busy == 0) begin
         if (Ack) rx_busy <= 2;
      end else begin
         rx_busy <= rx_busy - 1;
         if (rx_busy == 1) rx_rd <= rx_rd + 1;
      end
   end

   // Transmit FIFO model: logs each pushed byte.
   logic [7:0] tx_log [0:255];
   int tx_n = 0;
   int tx_busy = 0;
   assign Busy = (tx_busy != 0);
   always @(posedge FIFO_Clk) begin
      if (tx_busy == 0) begin
         if (Send) begin
            tx_busy <= 2;
            tx_log[8'(tx_n)] <= TxData;
            tx_n <= tx_n + 1;
         end
      end else begin
         tx_busy <= tx_busy - 1;
      end
   end

   // Bus slave and strobe monitors.
   logic [31:0] rd_value;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [7:0]  wr_addr = 8'h0;
   logic [7:0]  rd_addr = 8'h0;
   logic [31:0] wr_data = 32'h0;
   logic        both_hi = 1'b0;
   always @(posedge FIFO_Clk) begin
      RdData <= Read ? rd_value : 32'h0;
      if (Write) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= Address;
         wr_data <= WrData;
      end
      if (Read) begin
         rd_cnt  <= rd_cnt + 1;
         rd_addr <= Address;
      end
      if (Write && Read) both_hi <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge FIFO_Clk);
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_mem[rx_wr[5:0]] = b;
      rx_wr = rx_wr + 1;
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while ((rx_rd != rx_wr || AckBusy) && k < 400) begin
         @(negedge FIFO_Clk);
         k++;
      end
      check(tag, 32'(k < 400), 32'd1);
   endtask

   task automatic wait_tx(input string tag, input int target);
      int k;
      k = 0;
      while (tx_n < target && k < 400) begin
         @(negedge FIFO_Clk);
         k++;
      end
      check(tag, 32'(k < 400), 32'd1);
   endtask

   int wr0, rd0, tx0;

   initial begin
      nReset   = 1'b0;
      TxCount  = 10'd0;
      rd_value = 32'h0;
      cycles(3);
      check("rst_ack",   32'(Ack), 32'd0);
      check("rst_send",  32'(Send), 32'd0);
      check("rst_strb",  32'({Write, Read}), 32'd0);
      check("rst_err",   32'(ErrorCount), 32'd0);
      nReset = 1'b1;
      cycles(2);

      // Write 0x12345678 to 0x10.
      wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_n;
      push_rx(8'h57); push_rx(8'h10); push_rx(8'h78);
      push_rx(8'h56); push_rx(8'h34); push_rx(8'h12);
      wait_drain("w_drain");
      wait_tx("w_tx", tx0 + 1);
      cycles(6);
      check("w_count",  32'(wr_cnt - wr0), 32'd1);
      check("w_addr",   32'(wr_addr), 32'h10);
      check("w_data",   wr_data, 32'h12345678);
      check("w_nord",   32'(rd_cnt - rd0), 32'd0);
      check("w_txn",    32'(tx_n - tx0), 32'd1);
      check("w_resp",   32'(tx_log[8'(tx0)]), 32'h06);

      // Read 0x20 -> 0xA1B2C3D4.
      wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_n;
      rd_value = 32'hA1B2C3D4;
      push_rx(8'h52); push_rx(8'h20);
      wait_tx("r_tx", tx0 + 4);
      cycles(6);
      check("r_count",  32'(rd_cnt - rd0), 32'd1);
      check("r_addr",   32'(rd_addr), 32'h20);
      check("r_nowr",   32'(wr_cnt - wr0), 32'd0);
      check("r_b0",     32'(tx_log[8'(tx0)]), 32'hD4);
      check("r_b1",     32'(tx_log[8'(tx0 + 1)]), 32'hC3);
      check("r_b2",     32'(tx_log[8'(tx0 + 2)]), 32'hB2);
      check("r_b3",     32'(tx_log[8'(tx0 + 3)]), 32'hA1);
      check("r_txn",    32'(tx_n - tx0), 32'd4);
      check("r_wrhold", WrData, 32'h12345678);

      // Bad command 0x41 -> NAK, then a read of 0x00 still works.
      wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_n;
      push_rx(8'h41);
      wait_tx("n_tx", tx0 + 1);
      cycles(6);
      check("n_resp",   32'(tx_log[8'(tx0)]), 32'h15);
      check("n_err",    32'(ErrorCount), 32'd1);
      check("n_nostrb", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
      tx0 = tx_n;
      rd_value = 32'h55AA0102;
      push_rx(8'h52); push_rx(8'h00);
      wait_tx("n2_tx", tx0 + 4);
      cycles(6);
      check("n2_addr",  32'(rd_addr), 32'h00);
      check("n2_b0",    32'(tx_log[8'(tx0)]), 32'h02);
      check("n2_b3",    32'(tx_log[8'(tx0 + 3)]), 32'h55);

      // Timeout after byte 3 of a write.
      wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_n;
      push_rx(8'h57); push_rx(8'h10); push_rx(8'h78);
      wait_drain("t_drain");
      cycles(int'(TO) + 10);
      check("t_nowr",   32'(wr_cnt - wr0), 32'd0);
      check("t_notx",   32'(tx_n - tx0), 32'd0);
      check("t_err",    32'(ErrorCount), 32'd2);

      // Transmit FIFO full during a read response, then drained.
      rd0 = rd_cnt; tx0 = tx_n;
      TxCount = 10'd1023;
      rd_value = 32'h11223344;
      push_rx(8'h52); push_rx(8'h40);
      wait_drain("f_drain");
      cycles(40);
      check("f_send",   32'(Send), 32'd0);
      check("f_notx",   32'(tx_n - tx0), 32'd0);
      check("f_rd",     32'(rd_cnt - rd0), 32'd1);
      check("f_addr",   32'(rd_addr), 32'h40);
      TxCount = 10'd1000;
      wait_tx("f_tx", tx0 + 4);
      cycles(6);
      check("f_b0",     32'(tx_log[8'(tx0)]), 32'h44);
      check("f_b1",     32'(tx_log[8'(tx0 + 1)]), 32'h33);
      check("f_b2",     32'(tx_log[8'(tx0 + 2)]), 32'h22);
      check("f_b3",     32'(tx_log[8'(tx0 + 3)]), 32'h11);

      // Reset mid-write, then a fresh write completes.
      wr0 = wr_cnt;
      push_rx(8'h57); push_rx(8'h11); push_rx(8'h78);
      wait_drain("m_drain");
      cycles(3);
      nReset = 1'b0;
      @(negedge FIFO_Clk);
      check("m_ack",    32'(Ack), 32'd0);
      check("m_send",   32'(Send), 32'd0);
      check("m_strb",   32'({Write, Read}), 32'd0);
      check("m_txd",    32'(TxData), 32'd0);
      check("m_addr",   32'(Address), 32'd0);
      check("m_wrd",    WrData, 32'd0);
      check("m_err",    32'(ErrorCount), 32'd0);
      cycles(2);
      nReset = 1'b1;
      cycles(2);
      tx0 = tx_n;
      push_rx(8'h57); push_rx(8'h22); push_rx(8'hEF);
      push_rx(8'hBE); push_rx(8'hAD); push_rx(8'hDE);
      wait_drain("m2_drain");
      wait_tx("m2_tx", tx0 + 1);
      cycles(6);
      check("m2_count", 32'(wr_cnt - wr0), 32'd1);
      check("m2_addr",  32'(wr_addr), 32'h22);
      check("m2_data",  wr_data, 32'hDEADBEEF);
      check("m2_resp",  32'(tx_log[8'(tx0)]), 32'h06);
      check("m2_err",   32'(ErrorCount), 32'd0);
      check("no_both",  32'(both_hi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rs232_register_bridge.md
RS232_REGISTER_BRIDGE -- requirements
Module: rs232_register_bridge

Interface
REQ-001 SHALL have parameter TimeoutBits, default 20, meaning the width of the inter-byte timeout counter.
REQ-002 SHALL have parameter Timeout, default 20'd500000, meaning the FIFO_Clk cycles allowed between bytes of one packet (10 ms at 50 MHz).
REQ-003 SHALL have the port FIFO_Clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have the port nReset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have the port RxCount  in  10  bytes waiting in the receive FIFO.
REQ-006 SHALL have the port RxData  in  8  receive FIFO head byte, valid while RxCount != 0.
REQ-007 SHALL have the port Ack  out  1  pop request to the receive FIFO.
REQ-008 SHALL have the port AckBusy  in  1  receive FIFO pop in progress.
REQ-009 SHALL have the port TxCount  in  10  bytes queued in the transmit FIFO.
REQ-010 SHALL have the port TxData  out  8  byte to push into the transmit FIFO.
REQ-011 SHALL have the port Send  out  1  push request to the transmit FIFO.
REQ-012 SHALL have the port Busy  in  1  transmit FIFO push in progress.
REQ-013 SHALL have the port Address  out  8  register bus address.
REQ-014 SHALL have the port WrData  out  32  register bus write data.
REQ-015 SHALL have the port Write  out  1  one-cycle write strobe.
REQ-016 SHALL have the port Read  out  1  one-cycle read strobe.
REQ-017 SHALL have the port RdData  in  32  read data, sampled exactly one cycle after Read.
REQ-018 SHALL have the port ErrorCount  out  8  saturating count of aborted or rejected packets.

Function
REQ-019 SHALL use this packet format: byte0 command, 0x57 'W' or 0x52 'R'; byte1 address; for 'W' only, bytes2-5 data, LSB first.
REQ-020 SHALL pop a byte only when RxCount != 0 and AckBusy = 0: capture RxData and set Ack; clear Ack in the first cycle AckBusy = 1; wait for AckBusy = 0 before the next pop.
REQ-021 SHALL push a byte only when TxCount < 10'd1023 and Busy = 0: drive TxData and set Send; clear Send in the first cycle Busy = 1; wait for Busy = 0 before the next push; hold TxData stable while Send = 1.
REQ-022 SHALL implement states IDLE, CMD, ADDR, DATA, EXEC_W, EXEC_R, CAPTURE, RESP.
REQ-023 SHALL transition IDLE->CMD when a byte is available.
REQ-024 SHALL transition CMD->ADDR on 'W' or 'R'; any other command byte SHALL queue one response byte 0x15 (NAK), increment ErrorCount, then go RESP.
REQ-025 SHALL transition ADDR->DATA for 'W' and ADDR->EXEC_R for 'R'.
REQ-026 SHALL, in DATA, collect 4 bytes into WrData[7:0], [15:8], [23:16], [31:24] in that order, then go EXEC_W.
REQ-027 SHALL, in EXEC_W, pulse Write for one cycle with Address/WrData stable, queue response 0x06, then go RESP.
REQ-028 SHALL, in EXEC_R, pulse Read for one cycle, then go CAPTURE; CAPTURE SHALL latch RdData on the next cycle, queue its 4 bytes LSB first, then go RESP.
REQ-029 SHALL, in RESP, push the queued 1 or 4 bytes in order, then return to IDLE.
REQ-030 SHALL hold Address and WrData between transactions; Write and Read SHALL never be high in the same cycle.
REQ-031 SHALL reload the timeout counter on every completed pop and count only in ADDR or DATA while RxCount = 0.
REQ-032 SHALL, on timeout expiry, abort to IDLE with no bus strobe and no response, and increment ErrorCount.
REQ-033 SHALL saturate ErrorCount at 8'hFF.
REQ-034 SHALL, in RESP with the transmit FIFO full (TxCount = 1023), stall without dropping bytes; the timeout SHALL NOT apply.
REQ-035 SHALL leave receive bytes arriving during EXEC/CAPTURE/RESP in the receive FIFO until IDLE.

Reset
REQ-036 SHALL, while nReset = 0, clear Ack, Send, Write, Read, TxData, Address, WrData and ErrorCount to 0, put the state machine in IDLE, and clear the timeout counter and byte index.
REQ-037 SHALL, on reset mid-packet, discard the partial packet; after release it SHALL resume from IDLE with the next FIFO byte.

Verification
REQ-038 SHALL cover: RX 57 10 78 56 34 12 -> single Write pulse, Address=0x10, WrData=0x12345678; TX 06.
REQ-039 SHALL cover: RX 52 20, RdData=0xA1B2C3D4 -> single Read pulse, Address=0x20; TX D4 C3 B2 A1.
REQ-040 SHALL cover: RX 41 -> TX 15, ErrorCount=1, no strobe; a following 52 00 is served normally.
REQ-041 SHALL cover: RX 57 10 78, then silence for Timeout+10 cycles -> no Write, no TX, ErrorCount+1; back in IDLE.
REQ-042 SHALL cover: TxCount held at 1023 during a read response -> Send stays 0; TxCount dropped to 1000 -> all 4 bytes sent in order.
REQ-043 SHALL cover: nReset asserted after byte 3 of a write -> all outputs 0; a new 57 packet after release completes correctly.
